f_run_monitor: RTL
==================

Name: f_run_monitor

Overview:
Downstream consumer of the sequence-detector FSM's Moore output F (f_in here). Measures each contiguous high run of F in clock cycles and queues the run lengths in a small FIFO. A valid/ready interface drains the FIFO. Also keeps a total count of completed runs and a sticky overflow flag, for use by a display or host-side reader.

Parameters:
CNT_W, 8, width of run-length counter and of each FIFO entry
FIFO_DEPTH, 4, number of FIFO entries; power of two, at least 2
MIN_RUN, 1, shortest run (cycles) that is recorded; shorter runs are discarded silently

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
en  input  1  monitor enable; sampled on clk
f_in  input  1  detector output F, synchronous to clk
run_len  output  CNT_W  run length at FIFO head; 0 when FIFO empty
run_valid  output  1  FIFO non-empty
run_ready  input  1  consumer accepts head entry when run_valid=1
total_runs  output  16  count of completed qualifying runs, including dropped ones
busy  output  1  high while a run is being measured (state RUN)
overflow  output  1  sticky; set when a qualifying run is dropped because the FIFO is full

Behaviour:
- Reset (rst=1, asynchronous) clears: state=IDLE, run counter=0, FIFO pointers and count=0, run_len=0, run_valid=0, total_runs=0, busy=0, overflow=0. Reset in mid-run discards that run.
- All other state updates on rising clk.
- FSM, two states:
  - IDLE: if en=1 and f_in=1 -> RUN, counter=1. Otherwise stay in IDLE.
  - RUN: if en=0 -> IDLE; discard the run, no push, total_runs unchanged. Else if f_in=1 -> stay, counter+1, saturating at 2^CNT_W-1. Else (f_in=0) -> IDLE and the run ends.
- Run end: if counter >= MIN_RUN, total_runs+1 (wraps 65535->0) and push counter into the FIFO. If counter < MIN_RUN, nothing is recorded.
- busy = (state==RUN), registered.
- Latency: if f_in is last seen high at edge k and low at edge k+1, the entry is pushed at edge k+1. run_valid is high in the cycle after edge k+1 when the FIFO was empty.
- Run length equals the number of rising edges at which f_in=1 in RUN, counting the entry edge.
- A single-cycle gap (1,0,1) yields two runs. With f_in held high, no entry is produced until it falls.
- FIFO behaviour:
  - Pop occurs when run_valid=1 and run_ready=1 at a rising edge.
  - run_ready while empty has no effect.
  - run_len/run_valid derive from registered FIFO state only; there is no combinational path from f_in.
  - Simultaneous push and pop when full: both occur; count stays FIFO_DEPTH and no overflow.
  - Push when full with no pop: entry dropped, overflow set, total_runs still increments.
  - Simultaneous push and pop when empty: the popped entry is not the new one (run_valid was 0), so only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH; entries leave in push order.
- overflow clears only on rst.
- en=0 does not block FIFO reads.

Test Plan:
- Reset then idle: rst pulse mid-cycle with f_in=0 -> all outputs 0 immediately (before the next clk edge), stay 0 for 10 cycles.
- Single run: en=1, f_in high for exactly 3 cycles then low, run_ready=0 -> run_valid=1 with run_len=3 one cycle after the fall, busy high for 3 cycles, total_runs=1. Then run_ready=1 for one cycle -> run_valid=0, run_len=0.
- Ordering/wrap: runs of length 1,2,3,4,5 with reads interleaved so each push follows a pop -> run_len is read out as 1,2,3,4,5 in order (pointers wrap past entry 3), overflow=0.
- Overflow: run_ready=0, five runs of lengths 2,2,2,2,7 -> FIFO holds four 2s, overflow=1, total_runs=5. Draining yields exactly four entries of value 2.
- Full plus simultaneous pop: FIFO full; a run ends (length 6) on the same edge as a pop -> count stays 4, overflow=0, last entry read out is 6.
- Abort and saturation:
  - en dropped in mid-run after 4 high cycles -> no entry, total_runs unchanged.
  - f_in high 300 cycles with CNT_W=8 -> entry 255.
  - MIN_RUN=3 with a 2-cycle run -> nothing recorded.

Source files
------------

// File: rtl/f_run_monitor.sv
// Run-length monitor for the detector output F: measures each contiguous high run,
// queues qualifying lengths in a small FIFO drained over valid/ready, and keeps run statistics.
//
// state | meaning
// IDLE  | waiting for f_in high while enabled
// RUN   | measuring a high run of f_in; counter holds edges seen so far
module f_run_monitor #(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_RUN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             f_in,
    output logic [CNT_W-1:0] run_len,
    output logic             run_valid,
    input  logic             run_ready,
    output logic [15:0]      total_runs,
    output logic             busy,
    output logic             overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_RUN_C = CNT_W'(MIN_RUN);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [15:0]        total_q, total_d;
    logic               ovf_q, ovf_d;

    logic run_end;
    logic qualify;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        run_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && f_in) begin
                    state_d = RUN;
                    cnt_d   = CNT_ONE;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (f_in) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    run_end = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    always_comb begin
        fifo_empty = (occ_q == '0);
        fifo_full  = (occ_q == OCC_FULL);
        qualify    = run_end && (cnt_q >= MIN_RUN_C);
        pop        = !fifo_empty && run_ready;
        push       = qualify && (!fifo_full || pop);
        drop       = qualify && fifo_full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        total_d  = total_q;
        ovf_d    = ovf_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        if (qualify) begin
            total_d = total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            total_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            total_q  <= total_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= cnt_q;
        end
    end

    // Outputs come from registered state only; nothing from f_in reaches them combinationally.
    always_comb begin
        run_valid  = !fifo_empty;
        run_len    = fifo_empty ? '0 : mem_q[rd_ptr_q];
        total_runs = total_q;
        busy       = (state_q == RUN);
        overflow   = ovf_q;
    end

endmodule
